// File: rtl/mu0_run_pkg.sv
// mu0_run_pkg: shared state encoding and default tick period for the MU0 run controller
package mu0_run_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_DONE = 2'd3
  } state_t;
  localparam int unsigned MU0_DEFAULT_DIV = 32'd6318000;
endpackage

// File: rtl/mu0_run_ctrl_div.sv
// clk_enable_div: loadable modulo-period counter producing a terminal-count strobe; a zero period is clamped to one
module clk_enable_div #(
  parameter int          W         = 32,
  parameter int unsigned RESET_DIV = 6318000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         run,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);
  localparam logic [W-1:0] RST_PERIOD = (RESET_DIV == 0) ? W'(1) : W'(RESET_DIV);
  logic [W-1:0] period_q, period_d, count_q, count_d;
  assign tc = run & (count_q == period_q - 1'b1);
  // next period on load, counter restarts on load/clear/wrap
  always_comb begin
    period_d = load ? ((load_value == '0) ? W'(1) : load_value) : period_q;
    count_d  = (load | clear | tc) ? '0 : (run ? count_q + 1'b1 : count_q);
  end
  // period and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= RST_PERIOD;
      count_q  <= '0;
    end else begin
      period_q <= period_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/mu0_run_ctrl.sv
// mu0_run_ctrl: MU0 run/step controller emitting single-cycle cpu_ce pulses; define MU0_BREAKPOINT_EN for a PC breakpoint
module mu0_run_ctrl
  import mu0_run_pkg::*;
#(
  parameter int          DIV_WIDTH   = 32,
  parameter int unsigned DEFAULT_DIV = MU0_DEFAULT_DIV,
  parameter int          CNT_WIDTH   = 16
`ifdef MU0_BREAKPOINT_EN
  ,
  parameter int          ADDR_WIDTH  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_tgl,
  input  logic                  step_req,
  input  logic                  halt_req,
  input  logic                  done,
  input  logic                  div_load,
  input  logic [DIV_WIDTH-1:0]  div_value,
  output logic                  cpu_ce,
  output logic                  enable,
  output logic                  slow_clk,
  output logic [1:0]            state,
  output logic [CNT_WIDTH-1:0]  tick_count
`ifdef MU0_BREAKPOINT_EN
  ,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] bp_addr,
  input  logic                  bp_en,
  output logic                  bp_hit
`endif
);
  state_t               state_q, state_d;
  logic                 start_q, start_req, tc, clr, ce, bp_stop;
  logic                 slow_q, slow_d, enable_q;
  logic [CNT_WIDTH-1:0] tick_q, tick_d;
`ifdef MU0_BREAKPOINT_EN
  logic bp_q, bp_d;
  assign bp_stop = bp_en & (pc == bp_addr);
  assign bp_hit  = bp_q;
`else
  assign bp_stop = 1'b0;
`endif
  assign start_req  = start_tgl ^ start_q;
  assign cpu_ce     = ce & ~reset;
  assign enable     = enable_q;
  assign slow_clk   = slow_q;
  assign state      = state_q;
  assign tick_count = tick_q;

  clk_enable_div #(.W(DIV_WIDTH), .RESET_DIV(DEFAULT_DIV)) u_div (
    .clk       (clk),
    .rst       (reset),
    .clear     (clr),
    .run       (state_q == ST_RUN),
    .load      (div_load),
    .load_value(div_value),
    .tc        (tc)
  );

  // next state, tick pulse and counters; in RUN: done > halt > breakpoint > tick
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    ce      = 1'b0;
`ifdef MU0_BREAKPOINT_EN
    bp_d    = bp_q & ~start_req;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end else if (step_req) state_d = ST_STEP;
      end
      ST_RUN: begin
        if (done) state_d = ST_DONE;
        else if (halt_req) state_d = ST_IDLE;
        else if (tc & bp_stop) begin
          state_d = ST_IDLE;
`ifdef MU0_BREAKPOINT_EN
          bp_d    = 1'b1;
`endif
        end else ce = tc & ~div_load;
      end
      ST_STEP: begin
        ce      = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        if (start_req) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
    endcase
    tick_d = clr ? '0 : (ce ? tick_q + 1'b1 : tick_q);
    slow_d = slow_q ^ ce;
  end

  // state, start-edge copy and status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      start_q  <= start_tgl;
      slow_q   <= 1'b0;
      enable_q <= 1'b0;
      tick_q   <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_tgl;
      slow_q   <= slow_d;
      enable_q <= (state_d == ST_RUN);
      tick_q   <= tick_d;
    end
  end

`ifdef MU0_BREAKPOINT_EN
  // sticky breakpoint flag
  always_ff @(posedge clk) begin
    if (reset) bp_q <= 1'b0;
    else bp_q <= bp_d;
  end
`endif
endmodule

// File: doc/mu0_run_ctrl.md
Name: mu0_run_ctrl

Overview:
- Run/step controller for the MU0 core.
- Replaces the gated slow clock with a single-cycle clock-enable pulse (cpu_ce) in the clk domain.
- Period is programmable at runtime. Supports free-run, single-step, halt, and stop-on-done.
- Sits between the UART control block and the mu0 core; drives status LEDs via slow_clk/enable.

Parameters:
- DIV_WIDTH, 32: width of divider counter and div_value.
- DEFAULT_DIV, 6318000: tick period in clk cycles after reset.
- CNT_WIDTH, 16: width of tick_count.
- ADDR_WIDTH, 16: width of pc/bp_addr (used only with MU0_BREAKPOINT_EN).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_tgl  in  1  toggle-encoded start request; any level change = one request.
- step_req  in  1  one-cycle pulse: execute one tick.
- halt_req  in  1  one-cycle pulse: stop running.
- done  in  1  core reports program end (level).
- div_load  in  1  load div_value into period register.
- div_value  in  DIV_WIDTH  new period in clk cycles.
- cpu_ce  out  1  one-cycle core clock enable.
- enable  out  1  high in RUN.
- slow_clk  out  1  toggles on every cpu_ce (visual heartbeat).
- state  out  2  current FSM state encoding.
- tick_count  out  CNT_WIDTH  cpu_ce pulses since last start.

Behaviour:
- Reset values: state=IDLE, cpu_ce=0, enable=0, slow_clk=0, tick_count=0, divider count=0, period=DEFAULT_DIV. The start-edge register is loaded with the current start_tgl, so no spurious start follows reset.
- Start request: start_tgl differs from its registered copy. The copy updates every cycle.
- States: IDLE=0, RUN=1, STEP=2, DONE=3.
- IDLE:
  - On a start request: go to RUN, clear counter, clear tick_count.
  - On step_req: go to STEP.
- RUN:
  - Counter increments each cycle.
  - At count == period-1: counter wraps to 0, cpu_ce=1 for that cycle, slow_clk toggles, tick_count increments (wraps at 2^CNT_WIDTH).
  - done=1 goes to DONE; halt_req goes to IDLE. Neither asserts cpu_ce in that cycle.
  - A start request while in RUN is consumed and ignored.
- STEP: cpu_ce=1 for exactly one cycle (latency 1 clk after step_req), tick_count increments, then return to IDLE.
- DONE:
  - On a start request: go to RUN, clear counter and tick_count.
  - step_req and halt_req are ignored.
  - DONE is left only via a start request or reset.
- Priority within one cycle: reset > done > halt_req > start request > step_req.
- div_load:
  - Period register takes div_value next cycle and the counter clears.
  - div_value=0 is stored as 1, giving cpu_ce every cycle in RUN.
  - Allowed in any state.
  - If div_load coincides with terminal count, no cpu_ce is issued that cycle.
- enable = (state==RUN), registered.
- reset mid-RUN: the next cycle is IDLE with no cpu_ce.

Optional Feature:
- Macro: MU0_BREAKPOINT_EN.
- With the macro, extra ports are added:
  - pc  in  ADDR_WIDTH
  - bp_addr  in  ADDR_WIDTH
  - bp_en  in  1
  - bp_hit  out  1, sticky
- Breakpoint rule: in RUN at terminal count with bp_en=1 and pc==bp_addr, the cpu_ce is suppressed, state goes to IDLE, and bp_hit=1.
- bp_hit clears on reset or the next start request.
- STEP ignores breakpoints.
- Without the macro: no extra ports, no breakpoint logic.

Decomposition:
- Package mu0_run_pkg: state enum (IDLE/RUN/STEP/DONE), encoding constants, DEFAULT_DIV constant.
- Sub-module clk_enable_div: loadable modulo counter. Has clear and run inputs; produces a terminal-count pulse; applies the zero-to-one clamp.

Test Plan:
- Run with DEFAULT_DIV=4: reset, then toggle start_tgl 0->1. Expected: cpu_ce every 4th clk, slow_clk toggles each pulse, tick_count=3 after 12 clks.
- Done: done=1 during RUN. Expected: same cycle no cpu_ce, state=DONE, enable=0. step_req while in DONE produces no cpu_ce.
- Step from IDLE: step_req pulse. Expected: exactly one cpu_ce 1 clk later, tick_count +1, state returns to IDLE.
- Divider reload: div_load with div_value=0 during RUN. Expected: cpu_ce every clk. Reload div_value=3 gives one cpu_ce per 3 clks, with counter restart on load.
- Simultaneous events: done and halt_req together give DONE. reset with start_tgl=1 produces no start afterwards. Toggling start_tgl from DONE restarts with tick_count=0.
- Breakpoint (MU0_BREAKPOINT_EN): bp_en=1, bp_addr=16'h0005, pc=16'h0005 at terminal count. Expected: no cpu_ce, state=IDLE, bp_hit=1. bp_hit clears on the next start toggle.
